// File: rtl/serial_adder_if.sv
// Handshake and data bundle for serial_adder: operands and mode in, result and status out.
// The master drives start/sub/a/b/cin; the slave (the adder) drives busy/done/sum/cout/ovf.
interface serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: processes DIGIT bits per cycle, LSB slice first,
// with a registered carry between slices; IDLE -> RUN (N cycles) -> DONE (1 cycle).
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);

  localparam int DIG_SAFE = (DIGIT < 1) ? 1 : DIGIT;
  localparam int N        = WIDTH / DIG_SAFE;
  localparam int CW       = (N > 1) ? $clog2(N) : 1;
  localparam int RW       = (N > 1) ? (WIDTH - DIG_SAFE) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if ((DIGIT < 1) || ((WIDTH % DIG_SAFE) != 0)) begin : g_bad_cfg
      $error("serial_adder: WIDTH must be a positive integer multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [RW-1:0]    res_r;
  logic [CW-1:0]    cnt_r;
  logic             a_msb_r;
  logic             b_msb_r;
  logic             carry_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;

  logic [DIGIT:0]   slice_s;
  logic [WIDTH-1:0] res_next_s;

  // One DIGIT-wide slice of the sum, fed by the carry left by the previous slice.
  always_comb begin
    slice_s = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_r[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_r};
  end

  // Completed slices accumulate from the top, so the newest slice lands in the MSBs.
  generate
    if (N > 1) begin : g_multi
      assign res_next_s = {slice_s[DIGIT-1:0], res_r};
    end else begin : g_single
      assign res_next_s = slice_s[DIGIT-1:0];
    end
  endgenerate

  // Control FSM, operand shift registers and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      res_r   <= {RW{1'b0}};
      cnt_r   <= {CW{1'b0}};
      a_msb_r <= 1'b0;
      b_msb_r <= 1'b0;
      carry_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sum_r   <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            // Subtraction becomes a + ~b + ~cin, so only the captured operand differs.
            a_r     <= bus.a;
            b_r     <= bus.sub ? ~bus.b : bus.b;
            carry_r <= bus.sub ? ~bus.cin : bus.cin;
            a_msb_r <= bus.a[WIDTH-1];
            b_msb_r <= bus.sub ? ~bus.b[WIDTH-1] : bus.b[WIDTH-1];
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          a_r     <= a_r >> DIGIT;
          b_r     <= b_r >> DIGIT;
          res_r   <= res_next_s[WIDTH-1 -: RW];
          carry_r <= slice_s[DIGIT];
          busy_r  <= 1'b1;
          if (cnt_r == LAST) begin
            sum_r   <= res_next_s;
            cout_r  <= slice_s[DIGIT];
            // MSB carry-in recovered as a^b^s at the top bit.
            ovf_r   <= a_msb_r ^ b_msb_r ^ res_next_s[WIDTH-1] ^ slice_s[DIGIT];
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            cnt_r   <= cnt_r + CW'(1);
            done_r  <= 1'b0;
            state_r <= RUN;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=16, DIGIT=4): directed vectors push expected
// results; a monitor pops and compares on every done pulse.
module tb_serial_adder;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   done_cnt;
  int   ops_issued;
  exp_t exp_q[$];

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      exp_t e;
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        e = exp_q.pop_front();
        chk("sum",  {16'd0, bus.sum}, {16'd0, e.s});
        chk("cout", {31'd0, bus.cout}, {31'd0, e.c});
        chk("ovf",  {31'd0, bus.ovf},  {31'd0, e.o});
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic launch(input logic [15:0] ta, input logic [15:0] tb2, input logic tc, input logic ts);
    @(negedge clk);
    bus.a     = ta;
    bus.b     = tb2;
    bus.cin   = tc;
    bus.sub   = ts;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = 16'h0000;
    bus.b     = 16'h0000;
    bus.cin   = 1'b0;
    bus.sub   = 1'b0;
  endtask

  // Wait for done after a launch; returns the number of edges from the start edge.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done === 1'b1) break;
    end
  endtask

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb2, input logic tc,
                        input logic ts, input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    exp_q.push_back('{s: es, c: ec, o: eo});
    ops_issued++;
    launch(ta, tb2, tc, ts);
    chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
    wait_done(lat);
    chk("latency", lat, N);
    @(posedge clk);
    #1;
    chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
    chk("busy_idle", {31'd0, bus.busy}, 32'd0);
    chk("sum_hold", {16'd0, bus.sum}, {16'd0, es});
  endtask

  initial begin
    int lat;
    n_checks   = 0;
    n_fail     = 0;
    done_cnt   = 0;
    ops_issued = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.sub    = 1'b0;
    bus.a      = 16'h0000;
    bus.b      = 16'h0000;
    bus.cin    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_sum",  {16'd0, bus.sum},  32'd0);
    chk("rst_cout", {31'd0, bus.cout}, 32'd0);
    chk("rst_ovf",  {31'd0, bus.ovf},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op(16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_op(16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

    // Starts during RUN and during the done cycle must both be ignored.
    exp_q.push_back('{s: 16'h3333, c: 1'b0, o: 1'b0});
    ops_issued++;
    launch(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    bus.a     = 16'hAAAA;
    bus.b     = 16'h5555;
    bus.cin   = 1'b1;
    bus.sub   = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done === 1'b1) break;
      @(posedge clk);
      #1;
    end
    chk("done_seen", {31'd0, bus.done}, 32'd1);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("start_at_done_ignored", {31'd0, bus.busy}, 32'd0);
    repeat (N + 3) @(posedge clk);
    #1;
    chk("no_queued_op", {31'd0, bus.busy}, 32'd0);
    chk("sum_kept", {16'd0, bus.sum}, 32'h3333);

    // Reset in the second RUN cycle aborts with no done pulse.
    launch(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_sum",  {16'd0, bus.sum},  32'd0);
    chk("abort_cout", {31'd0, bus.cout}, 32'd0);
    chk("abort_ovf",  {31'd0, bus.ovf},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 3) @(posedge clk);
    #1;
    chk("abort_no_busy", {31'd0, bus.busy}, 32'd0);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("done_count", done_cnt, ops_issued);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; no other clock or reset SHALL exist.
REQ-002 Parameter WIDTH, default 16, SHALL set the operand and result width in bits.
REQ-003 Parameter DIGIT, default 4, SHALL set the number of bits processed per cycle.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port start, input, 1: request to launch an operation; sampled only in IDLE.
REQ-007 Port sub, input, 1: mode; 0 = add, 1 = subtract; captured with start.
REQ-008 Port a, input, WIDTH: operand A; captured with start.
REQ-009 Port b, input, WIDTH: operand B; captured with start.
REQ-010 Port cin, input, 1: carry-in (add) or borrow-in (subtract); captured with start.
REQ-011 Port busy, output, 1: high while an operation is in progress.
REQ-012 Port done, output, 1: one-cycle pulse when the result becomes valid.
REQ-013 Port sum, output, WIDTH: result.
REQ-014 Port cout, output, 1: carry-out; in subtract mode, 1 = no borrow.
REQ-015 Port ovf, output, 1: signed (two's-complement) overflow of the result.

Function
REQ-016 WIDTH SHALL be an integer multiple of DIGIT, with DIGIT >= 1; N = WIDTH/DIGIT; elaboration SHALL fail otherwise.
REQ-017 Add mode SHALL compute {cout,sum} = a + b + cin.
REQ-018 Subtract mode SHALL compute {cout,sum} = a + ~b + ~cin, i.e. a - b - cin.
REQ-019 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-020 In IDLE with start=1, the block SHALL capture a, b, cin and sub, initialise the digit counter to 0, and enter RUN on the next edge.
REQ-021 In RUN, each cycle SHALL process one DIGIT-bit slice, LSB slice first, using a registered carry that is passed between slices.
REQ-022 After slice N-1, the FSM SHALL move to DONE; DONE SHALL last exactly one cycle and then return to IDLE.
REQ-023 Latency: start sampled at edge T SHALL produce done=1 during the cycle following edge T+N.
REQ-024 sum, cout and ovf SHALL become valid in the same cycle as done and SHALL hold until the next accepted start.
REQ-025 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-026 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-027 done SHALL be 1 only in DONE.
REQ-028 start while busy=1 SHALL be ignored; no queuing SHALL occur and the captured operands SHALL stay unchanged.
REQ-029 start asserted in the same cycle as the done pulse SHALL be ignored; a new operation is accepted only from IDLE.
REQ-030 The input ports SHALL NOT affect an operation in flight once it has been captured.
REQ-031 With DIGIT = WIDTH (N=1), done SHALL assert one cycle after RUN, with the same FSM.
REQ-032 Carry SHALL wrap only into cout; sum SHALL be the result modulo 2^WIDTH.

Reset
REQ-033 rst_n=0 SHALL immediately force the IDLE state, busy=0, done=0, sum=0, cout=0, ovf=0, and clear the counter and the internal carry.
REQ-034 A reset asserted mid-operation SHALL abort the operation; no done pulse SHALL follow, and the first start after reset release SHALL be accepted normally.

Verification (WIDTH=16, DIGIT=4, N=4)
REQ-035 Add: a=0x1234, b=0x4321, cin=0, sub=0, start pulse -> done exactly 4 cycles later; sum=0x5555, cout=0, ovf=0.
REQ-036 Carry wrap: a=0xFFFF, b=0x0000, cin=1, sub=0 -> sum=0x0000, cout=1, ovf=0.
REQ-037 Signed overflow: a=0x7FFF, b=0x0001, cin=0, sub=0 -> sum=0x8000, cout=0, ovf=1.
REQ-038 Subtract: a=0x0005, b=0x0007, cin=0, sub=1 -> sum=0xFFFE, cout=0 (borrow), ovf=0; and a=0x8000, b=0x0001, cin=0, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
REQ-039 Ignored start: start again during RUN with a different a/b -> the result matches the first operands, and exactly one done pulse occurs.
REQ-040 Reset mid-operation: rst_n low at RUN cycle 2 -> all outputs 0 at once, no done pulse; then a=0x0001, b=0x0001 -> sum=0x0002.
